irq_ctrl: RTL

Memory-mapped interrupt controller sitting between the computer's peripheral interrupt lines (the irqs bus, timer on bit 0) and the CPU. It latches and masks the sources and picks the highest-priority one. It then sequences a single-level request/acknowledge/end-of-interrupt handshake with the CPU. It attaches to the memory bus like the other I/O blocks, using a cs, wen, addr, din and dout slave interface selected by one cs_io line from the address decoder.

---
 rtl/irq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped interrupt controller with fixed lowest-index priority
// Latches/masks sources and runs a single-level request/ack/EOI handshake with the CPU.
module irq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int NUM_IRQ = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic               wen,
    input  logic [2:0]         addr,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               irq_ack,
    output logic               irq_out,
    output logic [4:0]         irq_vec,
    output logic               in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] edge_mode;
    logic [NUM_IRQ-1:0] prev_in;
    logic               gie;
    logic [4:0]         vec_q;

    logic [NUM_IRQ-1:0] eligible;
    logic               any_elig;
    logic [4:0]         win;
    logic               bus_wr;
    logic               eoi;
    logic               take_ack;
    logic [NUM_IRQ-1:0] w1c_mask;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [NUM_IRQ-1:0] pend_next;

    assign eligible = pend & enable;
    assign any_elig = |eligible;
    assign bus_wr   = cs && wen;
    assign eoi      = bus_wr && (addr == 3'd3);
    assign take_ack = (state == ASSERT) && gie && any_elig && irq_ack;
    assign w1c_mask = (bus_wr && (addr == 3'd0)) ? din[NUM_IRQ-1:0] : '0;
    assign ack_mask = take_ack ? (NUM_IRQ'(1) << win) : '0;

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        win = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win = 5'(i);
            end
        end
    end

    // Edge sources: a fresh edge beats any clear in the same cycle. Level sources track the line.
    assign pend_next = (edge_mode & ((irq_in & ~prev_in) | (pend & ~(w1c_mask | ack_mask))))
                     | (~edge_mode & irq_in);

    always_comb begin
        dout = '0;
        case (addr)
            3'd0: dout[NUM_IRQ-1:0] = pend;
            3'd1: dout[NUM_IRQ-1:0] = enable;
            3'd2: dout[NUM_IRQ-1:0] = edge_mode;
            3'd3: begin
                if (any_elig) begin
                    dout[WIDTH-1] = 1'b1;
                    dout[4:0]     = win;
                end
            end
            3'd4: dout[0] = gie;
            default: dout = '0;
        endcase
    end

    assign irq_vec = (state == SERVICE) ? vec_q : win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      <= '0;
            enable    <= '0;
            edge_mode <= '0;
            prev_in   <= '0;
            gie       <= 1'b0;
            vec_q     <= 5'd0;
        end else begin
            pend    <= pend_next;
            prev_in <= irq_in;
            if (bus_wr && (addr == 3'd1)) enable    <= din[NUM_IRQ-1:0];
            if (bus_wr && (addr == 3'd2)) edge_mode <= din[NUM_IRQ-1:0];
            if (bus_wr && (addr == 3'd4)) gie       <= din[0];
            if (take_ack) vec_q <= win;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            irq_out    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gie && any_elig) begin
                        state   <= ASSERT;
                        irq_out <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (!gie || !any_elig) begin
                        state   <= IDLE;
                        irq_out <= 1'b0;
                    end else if (irq_ack) begin
                        state      <= SERVICE;
                        irq_out    <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    irq_out    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule
